beta_redirect_ctrl: RTL and testbench

Control-flow redirect controller in the execute stage. It takes the branch/jump unit outcome for each valid execute-stage instruction and decides whether a redirect is needed. When one is, it sequences the pipeline flush, then drives a redirect handshake to fetch with the new PC. Misaligned targets become an exception request instead of a redirect, and the block also keeps saturating control-flow event counters.

---
 rtl/beta_pkg.sv | 18 +
 rtl/beta_sat_counter.sv | 28 ++
 rtl/beta_redirect_ctrl.sv | 134 +++++++++++++
 tb/tb_beta_redirect_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared types and constants for the beta execute-stage control blocks.
package beta_pkg;

  // Redirect controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    EXC      = 2'd3
  } beta_redir_state_t;

  // Branch/jump unit operation classes.
  localparam logic [1:0] BJU_EN_NONE   = 2'b00;
  localparam logic [1:0] BJU_EN_BRANCH = 2'b01;
  localparam logic [1:0] BJU_EN_JAL    = 2'b10;
  localparam logic [1:0] BJU_EN_JALR   = 2'b11;

endpackage

// File: rtl/beta_sat_counter.sv
// Saturating up-counter: it counts inc_i pulses and sticks at all-ones.
module beta_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: increment unless the counter is already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/beta_redirect_ctrl.sv
// Execute-stage control-flow redirect controller. It flushes IF/ID, then
// hands the new PC to fetch, or raises a misaligned-target exception.
module beta_redirect_ctrl
  import beta_pkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNTWIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 exe_valid_i,
  input  logic [1:0]           exe_bju_en_i,
  input  logic                 bju_branch_taken_i,
  input  logic [DATAWIDTH-1:0] bju_next_pc_i,
  input  logic [DATAWIDTH-1:0] exe_pc_i,
  input  logic                 fetch_ready_i,
  input  logic                 exc_ack_i,
  output logic                 stall_exe_o,
  output logic                 flush_o,
  output logic                 redirect_valid_o,
  output logic [DATAWIDTH-1:0] redirect_pc_o,
  output logic                 exc_valid_o,
  output logic [DATAWIDTH-1:0] exc_pc_o,
  output logic [DATAWIDTH-1:0] exc_tval_o,
  output logic [CNTWIDTH-1:0]  cnt_branch_o,
  output logic [CNTWIDTH-1:0]  cnt_taken_o,
  output logic [CNTWIDTH-1:0]  cnt_jump_o
);

  // The flush counter is loaded with FLUSH_CYCLES-1 and runs down to zero.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  beta_redir_state_t    state_q, state_d;
  logic [3:0]           fcnt_q, fcnt_d;
  logic [DATAWIDTH-1:0] tgt_q, tgt_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;

  logic [DATAWIDTH-1:0] target;
  logic                 need_redir;
  logic                 misaligned;
  logic                 accept;
  logic                 inc_branch;
  logic                 inc_taken;
  logic                 inc_jump;

  // Decode the BJU outcome; only IDLE accepts a new execute-stage event.
  always_comb begin
    target = bju_next_pc_i;
    if (exe_bju_en_i == BJU_EN_JALR) target[0] = 1'b0;
    need_redir = exe_bju_en_i[1] ||
                 ((exe_bju_en_i == BJU_EN_BRANCH) && bju_branch_taken_i);
    misaligned = |target[1:0];
    accept     = (state_q == IDLE) && exe_valid_i;
    inc_branch = accept && (exe_bju_en_i == BJU_EN_BRANCH);
    inc_taken  = inc_branch && bju_branch_taken_i;
    inc_jump   = accept && exe_bju_en_i[1];
  end

  // Next-state logic for the flush / redirect / exception sequence.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    tgt_d   = tgt_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (accept && need_redir) begin
          tgt_d = target;
          if (misaligned) begin
            pc_d    = exe_pc_i;
            state_d = EXC;
          end else begin
            fcnt_d  = FLUSH_INIT;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == 4'd0) state_d = REDIRECT;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      REDIRECT: if (fetch_ready_i) state_d = IDLE;
      EXC:      if (exc_ack_i)     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, flush counter and latched target/PC registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      fcnt_q  <= 4'd0;
      tgt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tgt_q   <= tgt_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign stall_exe_o      = (state_q != IDLE);
  assign flush_o          = (state_q == FLUSH) || (state_q == EXC);
  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_pc_o    = (state_q == REDIRECT) ? tgt_q : '0;
  assign exc_valid_o      = (state_q == EXC);
  assign exc_pc_o         = (state_q == EXC) ? pc_q : '0;
  assign exc_tval_o       = (state_q == EXC) ? tgt_q : '0;

  beta_sat_counter #(.WIDTH(CNTWIDTH)) u_cnt_branch (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .inc_i (inc_branch),
    .cnt_o (cnt_branch_o)
  );

  beta_sat_counter #(.WIDTH(CNTWIDTH)) u_cnt_taken (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .inc_i (inc_taken),
    .cnt_o (cnt_taken_o)
  );

  beta_sat_counter #(.WIDTH(CNTWIDTH)) u_cnt_jump (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .inc_i (inc_jump),
    .cnt_o (cnt_jump_o)
  );

endmodule

// File: tb/tb_beta_redirect_ctrl.sv
// Directed bench for beta_redirect_ctrl: default instance plus a
// CNTWIDTH=2 / FLUSH_CYCLES=1 instance sharing the same stimulus.
module tb_beta_redirect_ctrl;
  import beta_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, exe_valid, taken, fetch_ready, exc_ack;
  logic [1:0]  en;
  logic [31:0] next_pc, exe_pc;

  logic        stall, flush, rv, ev;
  logic [31:0] rpc, epc, etval;
  logic [15:0] cb, ct, cj;

  logic        stall2, flush2, rv2, ev2;
  logic [31:0] rpc2, epc2, etval2;
  logic [1:0]  cb2, ct2, cj2;

  beta_redirect_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .exe_valid_i(exe_valid), .exe_bju_en_i(en),
    .bju_branch_taken_i(taken), .bju_next_pc_i(next_pc), .exe_pc_i(exe_pc),
    .fetch_ready_i(fetch_ready), .exc_ack_i(exc_ack),
    .stall_exe_o(stall), .flush_o(flush), .redirect_valid_o(rv),
    .redirect_pc_o(rpc), .exc_valid_o(ev), .exc_pc_o(epc), .exc_tval_o(etval),
    .cnt_branch_o(cb), .cnt_taken_o(ct), .cnt_jump_o(cj)
  );

  beta_redirect_ctrl #(.DATAWIDTH(32), .FLUSH_CYCLES(1), .CNTWIDTH(2)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .exe_valid_i(exe_valid), .exe_bju_en_i(en),
    .bju_branch_taken_i(taken), .bju_next_pc_i(next_pc), .exe_pc_i(exe_pc),
    .fetch_ready_i(fetch_ready), .exc_ack_i(exc_ack),
    .stall_exe_o(stall2), .flush_o(flush2), .redirect_valid_o(rv2),
    .redirect_pc_o(rpc2), .exc_valid_o(ev2), .exc_pc_o(epc2), .exc_tval_o(etval2),
    .cnt_branch_o(cb2), .cnt_taken_o(ct2), .cnt_jump_o(cj2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Step until both instances are back in IDLE, bounded.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((stall !== 1'b0 || stall2 !== 1'b0) && n < 30) begin
      step();
      n++;
    end
    check({name, " idle_reached"}, 32'(n < 30), 32'd1);
  endtask

  task automatic issue(input logic [1:0] e, input logic t, input logic [31:0] npc,
                       input logic [31:0] pc);
    en = e; taken = t; next_pc = npc; exe_pc = pc; exe_valid = 1'b1;
    step();
    exe_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  en;
    logic        taken;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        exp_redir;
    logic        exp_exc;
    logic [31:0] exp_tgt;
    int          d_b;
    int          d_t;
    int          d_j;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int b0, t0, j0, nflush, nred, first_red, done;
    logic [31:0] red_pc, e_pc, e_tval;
    logic exc_seen;
    string nm;

    vecs[0] = '{BJU_EN_BRANCH, 1'b1, 32'h0000_1040, 32'h0000_1000, 1, 0, 32'h0000_1040, 1, 1, 0};
    vecs[1] = '{BJU_EN_BRANCH, 1'b0, 32'h0000_1040, 32'h0000_1004, 0, 0, 32'h0,         1, 0, 0};
    vecs[2] = '{BJU_EN_NONE,   1'b1, 32'h0000_5000, 32'h0000_1008, 0, 0, 32'h0,         0, 0, 0};
    vecs[3] = '{BJU_EN_JAL,    1'b0, 32'h0000_2000, 32'h0000_100C, 1, 0, 32'h0000_2000, 0, 0, 1};
    vecs[4] = '{BJU_EN_JALR,   1'b0, 32'h0000_2003, 32'h0000_1100, 0, 1, 32'h0000_2002, 0, 0, 1};
    vecs[5] = '{BJU_EN_JALR,   1'b0, 32'h0000_2001, 32'h0000_1104, 1, 0, 32'h0000_2000, 0, 0, 1};
    vecs[6] = '{BJU_EN_JAL,    1'b0, 32'h0000_0002, 32'h0000_1200, 0, 1, 32'h0000_0002, 0, 0, 1};
    vecs[7] = '{BJU_EN_BRANCH, 1'b1, 32'h0000_1042, 32'h0000_1300, 0, 1, 32'h0000_1042, 1, 1, 0};
    vecs[8] = '{BJU_EN_BRANCH, 1'b0, 32'h0000_1043, 32'h0000_1304, 0, 0, 32'h0,         1, 0, 0};

    rstn = 1'b0; exe_valid = 1'b0; en = 2'b00; taken = 1'b0;
    next_pc = '0; exe_pc = '0; fetch_ready = 1'b0; exc_ack = 1'b0;

    // Reset state
    step(); step();
    check("rst stall", 32'(stall), 0);
    check("rst flush", 32'(flush), 0);
    check("rst redirect_valid", 32'(rv), 0);
    check("rst redirect_pc", rpc, 0);
    check("rst exc_valid", 32'(ev), 0);
    check("rst exc_pc", epc, 0);
    check("rst exc_tval", etval, 0);
    check("rst counters", {cb, ct}, 0);
    check("rst cnt_jump", 32'(cj), 0);
    rstn = 1'b1;
    step();

    // Saturation on the 2-bit instance, and single-cycle flush there
    fetch_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      issue(BJU_EN_JAL, 1'b0, 32'h0000_0400, 32'h0000_0040);
      if (k == 1) begin
        check("fc1 flush c1", 32'(flush2), 1);
        check("fc1 redirect c1", 32'(rv2), 0);
        step();
        check("fc1 flush c2", 32'(flush2), 0);
        check("fc1 redirect c2", 32'(rv2), 1);
        check("fc1 redirect_pc c2", rpc2, 32'h0000_0400);
        check("fc2 flush c2", 32'(flush), 1);
      end
      wait_idle($sformatf("sat%0d", k));
      check($sformatf("sat cnt_jump2 after %0d", k), 32'(cj2), (k > 3) ? 3 : k);
    end
    check("sat cnt_jump wide", 32'(cj), 5);

    // Table-driven single-event vectors
    for (int i = 0; i < 9; i++) begin
      b0 = int'(cb); t0 = int'(ct); j0 = int'(cj);
      fetch_ready = 1'b1;
      issue(vecs[i].en, vecs[i].taken, vecs[i].npc, vecs[i].pc);
      nflush = 0; nred = 0; first_red = 0; red_pc = '0;
      exc_seen = 1'b0; e_pc = '0; e_tval = '0; done = 0;
      for (int c = 1; c <= 20 && done == 0; c++) begin
        if (stall === 1'b0) begin
          done = 1;
        end else begin
          if (flush && !ev) nflush++;
          if (rv) begin
            nred++;
            if (first_red == 0) first_red = c;
            red_pc = rpc;
          end
          if (ev) begin
            exc_seen = 1'b1; e_pc = epc; e_tval = etval; exc_ack = 1'b1;
          end
          step();
          exc_ack = 1'b0;
        end
      end
      nm = $sformatf("vec%0d", i);
      check({nm, " done"}, 32'(done), 1);
      check({nm, " flush_cycles"}, 32'(nflush), vecs[i].exp_redir ? 2 : 0);
      check({nm, " redirect_count"}, 32'(nred), vecs[i].exp_redir ? 1 : 0);
      check({nm, " redirect_latency"}, 32'(first_red), vecs[i].exp_redir ? 3 : 0);
      check({nm, " redirect_pc"}, red_pc, vecs[i].exp_redir ? vecs[i].exp_tgt : 32'h0);
      check({nm, " exc_seen"}, 32'(exc_seen), 32'(vecs[i].exp_exc));
      check({nm, " exc_pc"}, e_pc, vecs[i].exp_exc ? vecs[i].pc : 32'h0);
      check({nm, " exc_tval"}, e_tval, vecs[i].exp_exc ? vecs[i].exp_tgt : 32'h0);
      check({nm, " idle redirect_pc"}, rpc, 0);
      check({nm, " d_branch"}, 32'(int'(cb) - b0), 32'(vecs[i].d_b));
      check({nm, " d_taken"}, 32'(int'(ct) - t0), 32'(vecs[i].d_t));
      check({nm, " d_jump"}, 32'(int'(cj) - j0), 32'(vecs[i].d_j));
      wait_idle(nm);
    end

    // Exception held until acknowledged; fetch_ready has no effect in EXC
    fetch_ready = 1'b1;
    issue(BJU_EN_JALR, 1'b0, 32'h0000_2003, 32'h0000_1100);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("exc_hold%0d valid", k), 32'(ev), 1);
      check($sformatf("exc_hold%0d tval", k), etval, 32'h0000_2002);
      check($sformatf("exc_hold%0d pc", k), epc, 32'h0000_1100);
      check($sformatf("exc_hold%0d flush_stall", k), {flush, stall}, 32'h3);
      check($sformatf("exc_hold%0d redirect", k), 32'(rv), 0);
      step();
    end
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("exc_ack idle stall", 32'(stall), 0);
    check("exc_ack exc_valid", 32'(ev), 0);
    check("exc_ack redirect", 32'(rv), 0);
    wait_idle("exc_hold");

    // Backpressure: redirect stable while fetch is not ready
    fetch_ready = 1'b0;
    issue(BJU_EN_BRANCH, 1'b1, 32'h0000_1040, 32'h0000_1000);
    step(); step();
    check("bp redirect rises", 32'(rv), 1);
    j0 = int'(cj);
    en = BJU_EN_JAL; next_pc = 32'h0000_3000; exe_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp%0d redirect_valid", k), 32'(rv), 1);
      check($sformatf("bp%0d redirect_pc", k), rpc, 32'h0000_1040);
      check($sformatf("bp%0d stall", k), 32'(stall), 1);
      step();
    end
    check("bp still waiting", 32'(rv), 1);
    exe_valid = 1'b0;
    fetch_ready = 1'b1;
    step();
    check("bp idle stall", 32'(stall), 0);
    check("bp idle redirect_pc", rpc, 0);
    check("bp cnt_jump unchanged", 32'(int'(cj) - j0), 0);
    wait_idle("bp");

    // Asynchronous reset during the first FLUSH cycle
    issue(BJU_EN_JAL, 1'b0, 32'h0000_3000, 32'h0000_1000);
    check("mid flush before reset", 32'(flush), 1);
    #2 rstn = 1'b0;
    #1;
    check("mid reset flush", 32'(flush), 0);
    check("mid reset stall", 32'(stall), 0);
    check("mid reset redirect", 32'(rv), 0);
    check("mid reset exc", 32'(ev), 0);
    check("mid reset counters", {cb, ct}, 0);
    check("mid reset cnt_jump", 32'(cj), 0);
    step();
    rstn = 1'b1;
    step();
    issue(BJU_EN_JAL, 1'b0, 32'h0000_0100, 32'h0000_0080);
    check("post flush c1", 32'(flush), 1);
    step();
    check("post flush c2", 32'(flush), 1);
    step();
    check("post redirect", 32'(rv), 1);
    check("post redirect_pc", rpc, 32'h0000_0100);
    check("post flush off", 32'(flush), 0);
    step();
    check("post idle", 32'(stall), 0);
    check("post cnt_jump", 32'(cj), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
